// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one-cycle rx_done strobe with frame/parity error flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int TW = ($clog2(STOP_TICKS) > 4) ? $clog2(STOP_TICKS) : 4;
  localparam int BW = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state, state_n;
  logic                   rx_meta, rx_s;
  logic [TW-1:0]          tick, tick_n;
  logic [BW-1:0]          bitc, bitc_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [DATA_BITS-1:0]   data_n;
  logic                   done_n, ferr_n;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_n;
  logic perr_q, perr_n;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tick      <= '0;
      bitc      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      bitc      <= bitc_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
      perr_q    <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bitc_n    = bitc;
    shreg_n   = shreg;
    data_n    = rx_data;
    done_n    = 1'b0;
    ferr_n    = frame_err;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = perr_q;
`endif
    unique case (state)
      // s_tick is deliberately ignored here; counting starts after entry to START.
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          tick_n  = '0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (tick == TW'(7)) begin
            tick_n = '0;
            if (!rx_s) begin
              state_n = S_DATA;
              bitc_n  = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (tick == TW'(15)) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            tick_n  = '0;
            if (bitc == BW'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end else begin
              bitc_n = bitc + BW'(1);
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (s_tick) begin
          if (tick == TW'(15)) begin
            par_bad_n = (^shreg) ^ rx_s;
            tick_n    = '0;
            state_n   = S_STOP;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (s_tick) begin
          if (tick == TW'(STOP_TICKS-1)) begin
            data_n  = shreg;
            ferr_n  = ~rx_s;
            done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_n  = par_bad;
`endif
            tick_n  = '0;
            state_n = S_IDLE;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
      end
    endcase
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the existing transmitter. It samples the serial line against the shared 16x oversampling tick (`s_tick`) and deserialises one LSB-first frame. It presents the received word with a one-cycle `rx_done` strobe plus error flags. It sits between the pad-side `rx` line and the same baud-rate tick generator that drives the transmitter.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `STOP_TICKS`, default 16: `s_tick` periods counted for the stop bit; legal values 16, 24, 32 (1, 1.5, 2 stop bits).
- `clk` in 1: single system clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_tick` in 1: one-`clk` pulse at 16x baud rate; ignored in IDLE.
- `rx` in 1: asynchronous serial input, idle high.
- `rx_data` out DATA_BITS: last received word, LSB = first data bit on the line.
- `rx_done` out 1: one-`clk` strobe when a frame completes.
- `frame_err` out 1: stop bit sampled low in the frame just reported.
- `parity_err` out 1: parity mismatch in the frame just reported; tied 0 without the macro.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All logic below uses the synchronised `rx_s`.
- Tick counter is `max(4, clog2(STOP_TICKS))` bits wide. It is cleared on every state entry and increments only on `s_tick`. Bit counter is `clog2(DATA_BITS)` bits wide.
- **IDLE**: wait for `rx_s == 0`. Then clear the tick counter and go to START.
- **START**: on `s_tick` with tick count 7 (mid start bit):
  - if `rx_s == 0`, clear the tick counter and the bit counter, then go to DATA;
  - if `rx_s == 1`, treat it as a glitch and return to IDLE with no outputs changed.
- **DATA**: on `s_tick` with tick count 15:
  - shift right into `shreg`, so `shreg <= {rx_s, shreg[DATA_BITS-1:1]}`;
  - clear the tick counter;
  - if bit count == DATA_BITS-1, go to PARITY (macro on) or STOP; otherwise increment the bit counter.
- **PARITY** (macro only): on `s_tick` with tick count 15, latch `par_bad = ^shreg ^ rx_s` (even parity), clear the tick counter, then go to STOP.
- **STOP**: on `s_tick` with tick count STOP_TICKS-1, in the same cycle:
  - `rx_data <= shreg`;
  - `frame_err <= ~rx_s`;
  - `parity_err <= par_bad`;
  - `rx_done <= 1`;
  - go to IDLE.
- A frame with a bad stop bit is still delivered, with `frame_err = 1`. The receiver re-arms immediately. A line held low re-enters START from IDLE.
- `rx_data`, `frame_err` and `parity_err` hold until the next `rx_done`. There is no consumer handshake, and an unread word is overwritten.

## Timing
- Reset values:
  - state IDLE, all counters 0, `shreg` 0;
  - `rx_data` 0, `rx_done` 0, `frame_err` 0, `parity_err` 0;
  - synchroniser flops 1.
- Reset asserted mid-frame aborts the frame with no `rx_done`. Reception resumes from IDLE once reset is released.
- Input latency: 2 `clk` cycles from `rx` to `rx_s`.
- `rx_done` is high for exactly the one `clk` cycle after the qualifying `s_tick` edge. Outputs are valid in that same cycle.
- Sample points:
  - start bit at tick 8;
  - each data and parity bit 16 ticks after the previous sample;
  - stop bit STOP_TICKS ticks after the last data or parity sample.
- The end of the stop sample and the next start edge can follow each other directly. The next frame's falling edge is accepted from the cycle after `rx_done`.
- `s_tick` coincident with the IDLE→START transition is not counted.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a PARITY state is inserted after DATA, one even-parity bit is expected per frame, and `parity_err` reports mismatches.
  - Undefined: the PARITY state and `par_bad` logic are absent, the frame is start + DATA_BITS + stop, and `parity_err` is constant 0.

## Test plan
All scenarios use `s_tick` every 4 `clk`, DATA_BITS=8 and STOP_TICKS=16.
- Clean frame 0xA5 → exactly one `rx_done` pulse, `rx_data` = 0xA5, `frame_err` = 0, `parity_err` = 0.
- Start glitch: `rx` low for 4 ticks, then high → return to IDLE, no `rx_done`, `rx_data` unchanged.
- Stop bit driven 0 on frame 0x3C → `rx_done` pulse, `rx_data` = 0x3C, `frame_err` = 1. The next clean frame 0x01 clears `frame_err`.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `rx_done` pulses, with `rx_data` = 0x00 then 0xFF.
- `reset` pulsed during data bit 3 of 0x55 → no `rx_done`, all outputs 0. The following frame 0xC3 is received correctly.
- With `UART_RX_PARITY_EN`: 0xA5 with parity bit 0 → `parity_err` = 0. 0xA5 with parity bit 1 → `parity_err` = 1 and `rx_data` = 0xA5.
